ram_access_ctrl: RTL

- Request/response controller sitting directly upstream of the team's 64x8 single-port RAM. It drives that RAM's data/addr/en pins and consumes its q output.
- Converts a valid/ready request stream (reads and writes) into correctly timed RAM pin activity, and returns read data on a valid/ready response channel.
- After reset it optionally scrubs every RAM location to a fixed value before accepting any traffic.

---
 rtl/ram_access_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// Request/response front end for the 64x8 single-port RAM. It optionally scrubs
// every location after reset, then serves single-beat writes and 2-edge reads.
//
// state  | meaning
// S_INIT | post-reset scrub, one write per cycle to every address
// S_IDLE | operational; accepts a write or a read when no response is pending
// S_RD   | RAM address registered last edge; capture ram_q at this edge
module ram_access_ctrl #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 6,
  parameter bit                 INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD} state_t;
  localparam state_t RST_STATE = INIT_EN ? S_INIT : S_IDLE;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                init_done_q, init_done_d;
  logic                ram_en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = init_done_q && (state_q == S_IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    ram_en_d    = 1'b0;
    ram_addr    = req_addr;
    ram_data    = req_wdata;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      S_INIT: begin
        ram_en_d = 1'b1;
        ram_addr = cnt_q[ADDR_W-1:0];
        ram_data = INIT_VAL;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        // Covers the no-scrub build, where IDLE is entered straight from reset.
        init_done_d = 1'b1;
        if (req_valid && req_ready) begin
          if (req_we) begin
            ram_en_d = 1'b1;
          end else begin
            rd_addr_d = req_addr;
            state_d   = S_RD;
          end
        end
      end
      S_RD: begin
        ram_addr    = rd_addr_q;
        rsp_rdata_d = ram_q;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The reset state is INIT, so the scrub write strobe must be held off while in reset.
  assign ram_en    = ram_en_d & rst_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

endmodule
